// File: rtl/usrt_tx.sv
// rtl/usrt_tx.sv - USRT transmit stage: push FIFO plus framed serialiser with TxClk
module usrt_tx #(
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          pClk,
  input  logic                          pReset,
  input  logic [7:0]                    wrData,
  input  logic                          wrValid,
  output logic                          wrReady,
  input  logic                          parityEn,
  input  logic                          parityOdd,
  output logic                          Tx,
  output logic                          TxClk,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifoCount
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int DW = $clog2(2 * CLK_DIV);
  localparam logic [AW:0]   DEPTH    = (AW + 1)'(FIFO_DEPTH);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(2 * CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } txStateT;

  logic [7:0]    fifoMem [FIFO_DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic [AW:0]   count;
  logic          push;
  logic          pop;

  txStateT       state;
  txStateT       stateNext;
  logic [DW-1:0] divCnt;
  logic [2:0]    bitIdx;
  logic [7:0]    txByte;
  logic          parEnReg;
  logic          parOddReg;
  logic          bitEnd;

  // Readiness comes from the registered count only, so a full FIFO refuses
  // a push even when the serialiser pops on the same edge.
  assign wrReady   = (count < DEPTH);
  assign push      = wrValid && wrReady;
  assign fifoCount = count;
  assign bitEnd    = (divCnt == DIV_LAST);
  assign busy      = (state != IDLE);

  // FIFO storage; validity is tracked by the pointers, so no reset is needed
  always_ff @(posedge pClk) begin
    if (push) begin
      fifoMem[wrPtr] <= wrData;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth
  always_ff @(posedge pClk or negedge pReset) begin
    if (!pReset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wrPtr <= wrPtr + 1'b1;
      end
      if (pop) begin
        rdPtr <= rdPtr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Frame state register
  always_ff @(posedge pClk or negedge pReset) begin
    if (!pReset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state and pop decision; STOP pops directly into START for gapless frames
  always_comb begin
    stateNext = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop       = 1'b1;
          stateNext = START;
        end
      end
      START: begin
        if (bitEnd) begin
          stateNext = DATA;
        end
      end
      DATA: begin
        if (bitEnd && (bitIdx == 3'd7)) begin
          stateNext = parEnReg ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (bitEnd) begin
          stateNext = STOP;
        end
      end
      STOP: begin
        if (bitEnd) begin
          if (count != '0) begin
            pop       = 1'b1;
            stateNext = START;
          end else begin
            stateNext = IDLE;
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Bit divider, data index and per-frame byte/parity settings captured at pop
  always_ff @(posedge pClk or negedge pReset) begin
    if (!pReset) begin
      divCnt    <= '0;
      bitIdx    <= '0;
      txByte    <= '0;
      parEnReg  <= 1'b0;
      parOddReg <= 1'b0;
    end else if (pop) begin
      divCnt    <= '0;
      bitIdx    <= '0;
      txByte    <= fifoMem[rdPtr];
      parEnReg  <= parityEn;
      parOddReg <= parityOdd;
    end else if (state == IDLE) begin
      divCnt <= '0;
    end else begin
      divCnt <= bitEnd ? '0 : divCnt + 1'b1;
      if ((state == DATA) && bitEnd) begin
        bitIdx <= bitIdx + 1'b1;
      end
    end
  end

  // Line encoding: Tx only moves at bit boundaries, TxClk rises mid-bit
  always_comb begin
    Tx    = 1'b1;
    TxClk = 1'b0;
    case (state)
      START:   Tx = 1'b0;
      DATA:    Tx = txByte[bitIdx];
      PARITY:  Tx = (^txByte) ^ parOddReg;
      default: Tx = 1'b1;
    endcase
    if (state != IDLE) begin
      TxClk = (divCnt >= DIV_HALF);
    end
  end

endmodule

// File: tb/tb_usrt_tx.sv
// tb/tb_usrt_tx.sv - directed self-checking bench for usrt_tx
module tb_usrt_tx;

  localparam int CLK_DIV    = 4;
  localparam int FIFO_DEPTH = 4;

  logic       pClk;
  logic       pReset;
  logic [7:0] wrData;
  logic       wrValid;
  logic       wrReady;
  logic       parityEn;
  logic       parityOdd;
  logic       Tx;
  logic       TxClk;
  logic       busy;
  logic [2:0] fifoCount;

  int vecCount  = 0;
  int missCount = 0;

  usrt_tx #(
    .CLK_DIV    (CLK_DIV),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .pClk      (pClk),
    .pReset    (pReset),
    .wrData    (wrData),
    .wrValid   (wrValid),
    .wrReady   (wrReady),
    .parityEn  (parityEn),
    .parityOdd (parityOdd),
    .Tx        (Tx),
    .TxClk     (TxClk),
    .busy      (busy),
    .fifoCount (fifoCount)
  );

  initial pClk = 1'b0;
  always #5 pClk = ~pClk;

  task automatic checkVec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecCount++;
    if (obs !== exp) begin
      missCount++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge pClk);
    #1;
  endtask

  // Called on cycle 0 of the start bit; returns on the cycle after the stop bit.
  task automatic frameCheck(input logic [7:0] d, input logic pe, input logic parBit);
    logic [10:0] bits;
    int n;
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = d[i];
    n = 9;
    if (pe) begin
      bits[9] = parBit;
      n = 10;
    end
    bits[n] = 1'b1;
    n = n + 1;
    for (int b = 0; b < n; b++) begin
      for (int c = 0; c < 2 * CLK_DIV; c++) begin
        checkVec($sformatf("tx %02h bit%0d", d, b), Tx, bits[b]);
        checkVec($sformatf("txClk %02h bit%0d", d, b), TxClk, (c >= CLK_DIV));
        checkVec($sformatf("busy %02h bit%0d", d, b), busy, 1'b1);
        tick();
      end
    end
  endtask

  // Push one byte while idle, flip the parity inputs after the pop, check the frame.
  task automatic sendFrame(input logic [7:0] d, input logic pe, input logic po, input logic parBit);
    parityEn  = pe;
    parityOdd = po;
    wrData    = d;
    wrValid   = 1'b1;
    tick();
    wrValid = 1'b0;
    checkVec("pushCount", fifoCount, 1);
    checkVec("pushBusy", busy, 0);
    checkVec("pushTx", Tx, 1);
    tick();
    checkVec("popCount", fifoCount, 0);
    parityEn  = ~pe;
    parityOdd = ~po;
    frameCheck(d, pe, parBit);
    checkVec("endBusy", busy, 0);
    checkVec("endTx", Tx, 1);
    checkVec("endCount", fifoCount, 0);
    parityEn  = 1'b0;
    parityOdd = 1'b0;
  endtask

  initial begin
    int n;
    pReset    = 1'b0;
    wrData    = 8'h00;
    wrValid   = 1'b0;
    parityEn  = 1'b0;
    parityOdd = 1'b0;
    #1;
    checkVec("rstTx", Tx, 1);
    checkVec("rstTxClk", TxClk, 0);
    checkVec("rstBusy", busy, 0);
    checkVec("rstReady", wrReady, 1);
    checkVec("rstCount", fifoCount, 0);
    repeat (2) tick();
    pReset = 1'b1;
    tick();

    // single byte, no parity: 0,1,0,1,0,0,1,0,1,1 over 80 cycles
    sendFrame(8'hA5, 1'b0, 1'b0, 1'b0);
    // parity frames of 88 cycles
    sendFrame(8'hA5, 1'b1, 1'b0, 1'b0);
    sendFrame(8'hA5, 1'b1, 1'b1, 1'b1);
    sendFrame(8'h00, 1'b1, 1'b1, 1'b1);
    repeat (3) tick();

    // FIFO full: six bytes held on wrValid, six gapless frames
    fork
      begin
        wrValid = 1'b1;
        wrData  = 8'h01;
        for (int i = 1; i <= 5; i++) begin
          checkVec($sformatf("fullReady%0d", i), wrReady, 1);
          tick();
          wrData = 8'(i + 1);
        end
        checkVec("fullCount", fifoCount, 4);
        checkVec("fullReady0", wrReady, 0);
        n = 0;
        while (wrReady !== 1'b1 && n < 200) begin
          tick();
          n++;
        end
        checkVec("fullWait", n, 77);
        tick();
        wrValid = 1'b0;
        checkVec("fullLastCount", fifoCount, 4);
      end
      begin
        repeat (2) tick();
        for (int k = 1; k <= 6; k++) frameCheck(8'(k), 1'b0, 1'b0);
        checkVec("fullEndBusy", busy, 0);
        checkVec("fullEndCount", fifoCount, 0);
        checkVec("fullEndTx", Tx, 1);
      end
    join
    repeat (3) tick();

    // push lands on the same edge as the pop out of STOP
    fork
      begin
        wrValid = 1'b1;
        wrData  = 8'h3C;
        tick();
        wrData = 8'hC3;
        tick();
        wrValid = 1'b0;
        checkVec("ppCount0", fifoCount, 1);
        repeat (79) tick();
        checkVec("ppCount1", fifoCount, 1);
        wrData  = 8'h5A;
        wrValid = 1'b1;
        tick();
        wrValid = 1'b0;
        checkVec("ppCount2", fifoCount, 1);
      end
      begin
        repeat (2) tick();
        frameCheck(8'h3C, 1'b0, 1'b0);
        frameCheck(8'hC3, 1'b0, 1'b0);
        frameCheck(8'h5A, 1'b0, 1'b0);
        checkVec("ppEndBusy", busy, 0);
        checkVec("ppEndCount", fifoCount, 0);
      end
    join
    repeat (3) tick();

    // reset during data bit 3 with two bytes queued
    wrValid = 1'b1;
    wrData  = 8'hA5;
    tick();
    wrData = 8'h11;
    tick();
    wrData = 8'h22;
    tick();
    wrValid = 1'b0;
    repeat (36) tick();
    checkVec("preRstTx", Tx, 0);
    checkVec("preRstTxClk", TxClk, 1);
    checkVec("preRstBusy", busy, 1);
    checkVec("preRstCount", fifoCount, 2);
    #2;
    pReset = 1'b0;
    #1;
    checkVec("midRstTx", Tx, 1);
    checkVec("midRstTxClk", TxClk, 0);
    checkVec("midRstBusy", busy, 0);
    checkVec("midRstCount", fifoCount, 0);
    checkVec("midRstReady", wrReady, 1);
    repeat (2) tick();
    pReset = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      checkVec($sformatf("postRstTx%0d", i), Tx, 1);
      checkVec($sformatf("postRstBusy%0d", i), busy, 0);
    end
    sendFrame(8'h81, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
